column_multiply_pipe: RTL and testbench

Next-generation column multiplier for the fixed-point matrix-inversion datapath. For one pivot operation it multiplies each of the MAT_SIZE-1 non-pivot row factors by every element of the normalised pivot column, producing the (MAT_SIZE-1)×MAT_SIZE subtractor array consumed by the column-update stage. Compared with the earlier fixed-latency unit, it adds:
- valid/ready backpressure with a stallable pipeline
- configurable multiplier latency
- optional round-to-nearest
- saturation with an overflow flag
- transaction-aligned opCnt pass-through

---
 rtl/column_multiply_pipe.sv | 126 ++++++++++++
 tb/tb_column_multiply_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/column_multiply_pipe.sv
// rtl/column_multiply_pipe.sv - stallable pivot-column multiplier with round/saturate output stage
module column_multiply_pipe #(
  parameter int MAT_SIZE        = 5,
  parameter int DATWIDTH        = 64,
  parameter int MAT_DWIDTH      = 46,
  parameter int MAT_FACTIONBITS = 14,
  parameter int MUL_LATENCY     = 5,
  parameter int ROUND_EN        = 1,
  parameter int SAT_EN          = 1
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [$clog2(MAT_SIZE):0]                             opCnt,
  input  logic [MAT_SIZE-1:0][DATWIDTH-1:0]                     opColumnNorm,
  input  logic [MAT_SIZE-1:0][DATWIDTH-1:0]                     mjk,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [$clog2(MAT_SIZE):0]                             out_opCnt,
  output logic [MAT_SIZE-2:0][MAT_SIZE-1:0][DATWIDTH-1:0]       columnSubstractor,
  output logic                                                  out_ovf
);

  localparam int ROWS   = MAT_SIZE - 1;
  localparam int OCW    = $clog2(MAT_SIZE) + 1;
  localparam int PW     = 2 * DATWIDTH;
  localparam int FRAC_U = DATWIDTH - MAT_DWIDTH + MAT_FACTIONBITS;
  localparam logic [PW-1:0]       RND     = (ROUND_EN != 0) ? (PW'(1) << (DATWIDTH - 2)) : '0;
  localparam logic [DATWIDTH-1:0] SAT_MAX = {1'b0, {(DATWIDTH-1){1'b1}}};
  localparam logic [DATWIDTH-1:0] SAT_MIN = {1'b1, {(DATWIDTH-1){1'b0}}};

  // Unnormalised rows share the product shift, so FRAC_U must fit below the Q1 point.
  if (MUL_LATENCY < 1 || FRAC_U < 0 || FRAC_U > DATWIDTH - 1) begin : g_param_check
    $error("column_multiply_pipe: unsupported parameterisation");
  end

  logic                                    adv;
  logic [ROWS-1:0][DATWIDTH-1:0]           sel_row;
  logic [ROWS-1:0][DATWIDTH-1:0]           s0_row;
  logic [MAT_SIZE-1:0][DATWIDTH-1:0]       s0_col;
  logic                                    s0_valid;
  logic [OCW-1:0]                          s0_opcnt;
  logic signed [PW-1:0]                    mul_p [MUL_LATENCY][ROWS][MAT_SIZE];
  logic [MUL_LATENCY-1:0]                  mul_valid;
  logic [OCW-1:0]                          mul_opcnt [MUL_LATENCY];
  logic [ROWS-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] res;
  logic                                    res_ovf;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !reset;

  // Skip the pivot row; indices past the last row clamp to it.
  always_comb begin
    int ec;
    ec = (int'(opCnt) > ROWS) ? ROWS : int'(opCnt);
    for (int p = 0; p < ROWS; p++) begin
      sel_row[p] = (p < ec) ? mjk[p] : mjk[p+1];
    end
  end

  always_comb begin
    logic signed [PW-1:0] sum;
    logic signed [PW-1:0] shf;
    logic                 e_ovf;
    sum     = '0;
    shf     = '0;
    e_ovf   = 1'b0;
    res     = '0;
    res_ovf = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < MAT_SIZE; c++) begin
        sum   = mul_p[MUL_LATENCY-1][r][c] + $signed(RND);
        shf   = sum >>> (DATWIDTH - 1);
        e_ovf = shf[PW-1:DATWIDTH-1] != {(DATWIDTH+1){shf[DATWIDTH-1]}};
        res[r][c] = (e_ovf && SAT_EN != 0) ? (shf[PW-1] ? SAT_MIN : SAT_MAX)
                                           : shf[DATWIDTH-1:0];
        res_ovf = res_ovf | e_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid          <= 1'b0;
      s0_opcnt          <= '0;
      s0_row            <= '0;
      s0_col            <= '0;
      mul_valid         <= '0;
      out_valid         <= 1'b0;
      out_opCnt         <= '0;
      out_ovf           <= 1'b0;
      columnSubstractor <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) begin
        mul_opcnt[k] <= '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < MAT_SIZE; c++)
            mul_p[k][r][c] <= '0;
      end
    end else if (adv) begin
      s0_valid <= in_valid;
      s0_opcnt <= opCnt;
      s0_row   <= sel_row;
      s0_col   <= opColumnNorm;

      mul_valid[0] <= s0_valid;
      mul_opcnt[0] <= s0_opcnt;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < MAT_SIZE; c++)
          mul_p[0][r][c] <= $signed(s0_row[r]) * $signed(s0_col[c]);
      for (int k = 1; k < MUL_LATENCY; k++) begin
        mul_valid[k] <= mul_valid[k-1];
        mul_opcnt[k] <= mul_opcnt[k-1];
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < MAT_SIZE; c++)
            mul_p[k][r][c] <= mul_p[k-1][r][c];
      end

      out_valid         <= mul_valid[MUL_LATENCY-1];
      out_opCnt         <= mul_opcnt[MUL_LATENCY-1];
      columnSubstractor <= res;
      out_ovf           <= res_ovf;
    end
  end

endmodule

// File: tb/tb_column_multiply_pipe.sv
// tb/tb_column_multiply_pipe.sv - scoreboard bench for column_multiply_pipe (round/sat and trunc/wrap builds)
module tb_column_multiply_pipe;

  typedef struct packed {
    logic [3:0]        opcnt;
    logic [3:0][63:0]  row_a;
    logic [3:0][63:0]  row_b;
    logic              ovf_a;
    logic              ovf_b;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset, in_valid, out_ready;
  logic [3:0]            opCnt;
  logic [4:0][63:0]      opColumnNorm, mjk;
  logic                  in_ready, out_valid, out_ovf;
  logic [3:0]            out_opCnt;
  logic [3:0][4:0][63:0] cs;
  logic                  t_in_ready, t_out_valid, t_out_ovf;
  logic [3:0]            t_out_opCnt;
  logic [3:0][4:0][63:0] t_cs;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, stall_mode = 0;
  logic                  prev_stall = 1'b0;
  logic [3:0][4:0][63:0] prev_cs, prev_t_cs;
  logic [3:0]            prev_opcnt;
  logic                  prev_ovf;

  localparam logic [63:0] H = 64'h4000000000000000;

  column_multiply_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .opCnt(opCnt),
    .opColumnNorm(opColumnNorm), .mjk(mjk), .out_valid(out_valid), .out_ready(out_ready),
    .out_opCnt(out_opCnt), .columnSubstractor(cs), .out_ovf(out_ovf));

  column_multiply_pipe #(.ROUND_EN(0), .SAT_EN(0)) dut_t (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t_in_ready), .opCnt(opCnt),
    .opColumnNorm(opColumnNorm), .mjk(mjk), .out_valid(t_out_valid), .out_ready(out_ready),
    .out_opCnt(t_out_opCnt), .columnSubstractor(t_cs), .out_ovf(t_out_ovf));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    out_ready = (stall_mode == 0) || (cyc % 3 == 0);
  endtask

  task automatic idle();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] oc, input logic [4:0][63:0] m, input logic [63:0] col,
                      input logic [3:0][63:0] ra, input logic [3:0][63:0] rb,
                      input logic oa, input logic ob);
    exp_t e;
    logic got;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      in_valid     = 1'b1;
      opCnt        = oc;
      mjk          = m;
      opColumnNorm = {5{col}};
      #1;
      if (in_ready) begin
        e.opcnt = oc; e.row_a = ra; e.row_b = rb; e.ovf_a = oa; e.ovf_b = ob;
        q.push_back(e);
        got = 1'b1;
      end
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++) idle();
    idle();
    #3;
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_t_out_valid"}, 64'(t_out_valid), 64'd0);
    chk({nm, "_out_ovf"}, 64'(out_ovf), 64'd0);
    chk({nm, "_out_opCnt"}, 64'(out_opCnt), 64'd0);
    chk({nm, "_data_zero"}, 64'(cs != '0 || t_cs != '0), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready && t_in_ready), 64'd1);
  endtask

  // Monitor: flush in-flight expectations on reset, check stall hold, pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_out_opCnt", 64'(out_opCnt), 64'(prev_opcnt));
        chk("hold_out_ovf", 64'(out_ovf), 64'(prev_ovf));
        chk("hold_data", 64'(cs != prev_cs || t_cs != prev_t_cs), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("out_opCnt", 64'(out_opCnt), 64'(e.opcnt));
          chk("out_ovf", 64'(out_ovf), 64'(e.ovf_a));
          chk("t_out_valid", 64'(t_out_valid), 64'd1);
          chk("t_out_opCnt", 64'(t_out_opCnt), 64'(e.opcnt));
          chk("t_out_ovf", 64'(t_out_ovf), 64'(e.ovf_b));
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
              chk($sformatf("rnd_sat[%0d][%0d]", r, c), cs[r][c], e.row_a[r]);
              chk($sformatf("trunc_wrap[%0d][%0d]", r, c), t_cs[r][c], e.row_b[r]);
            end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_cs    = cs;
      prev_t_cs  = t_cs;
      prev_opcnt = out_opCnt;
      prev_ovf   = out_ovf;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opCnt = '0; mjk = '0; opColumnNorm = '0;
    repeat (3) @(negedge clk);
    tick();
    reset = 1'b0;
    #1;
    check_cleared("reset");

    // 0.5 x 0.5 with latency measurement
    send(4'd4, {5{H}}, H, {4{64'h2000000000000000}}, {4{64'h2000000000000000}}, 1'b0, 1'b0);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      idle();
      #1;
      if (out_valid) lat = c;
    end
    chk("latency", 64'(lat), 64'd7);
    drain();

    // unnormalised 3.0 rows, opCnt 0 skips mjk[0]
    send(4'd0, {{4{64'h0000000300000000}}, 64'hDEADBEEFDEADBEEF}, H,
         {4{64'h0000000180000000}}, {4{64'h0000000180000000}}, 1'b0, 1'b0);
    // tag rows, opCnt 2 skips mjk[2]
    send(4'd2, {64'd50, 64'd40, 64'd30, 64'd20, 64'd10}, H,
         {64'd25, 64'd20, 64'd10, 64'd5}, {64'd25, 64'd20, 64'd10, 64'd5}, 1'b0, 1'b0);
    // -1 x -1 overflow: clamp vs wrap
    send(4'd4, {5{64'h8000000000000000}}, 64'h8000000000000000,
         {4{64'h7FFFFFFFFFFFFFFF}}, {4{64'h8000000000000000}}, 1'b1, 1'b1);
    // LSB x 0.5: round up vs floor
    send(4'd4, {5{64'd1}}, H, {4{64'd1}}, {4{64'd0}}, 1'b0, 1'b0);
    // opCnt beyond the matrix clamps to last row
    send(4'd9, {64'd50, 64'd40, 64'd30, 64'd20, 64'd10}, H,
         {64'd20, 64'd15, 64'd10, 64'd5}, {64'd20, 64'd15, 64'd10, 64'd5}, 1'b0, 1'b0);
    drain();

    // back-to-back stream under 1,0,0 backpressure with a mid-stream reset
    stall_mode = 1;
    for (int i = 0; i < 10; i++) begin
      logic [4:0][63:0] m;
      logic [3:0][63:0] ex;
      for (int j = 0; j < 4; j++) begin
        m[j]  = 64'((i * 16 + j + 1) * 256);
        ex[j] = 64'((i * 16 + j + 1) * 128);
      end
      m[4] = 64'h00000000FFFF0000;
      send(4'(4 + (i % 2) * 4), m, H, ex, ex, 1'b0, 1'b0);
      if (i == 5) begin
        repeat (10) idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_cleared("midreset");
      end
    end
    drain();
    stall_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
